// File: rtl/mips_ex_core.sv
// mips_ex_core
//   Combined decode/execute slice of the five-stage MIPS pipeline. Decodes the
//   main control word from the opcode, derives the 4-bit ALU operation from
//   ALUOp and funct, evaluates the ALU, and registers result/zero into the
//   EX/MEM boundary.
//
// Ports
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   instr[31:0]       : instruction word (opcode/rs/rt/rd/imm/funct)
//   rs_data, rt_data  : forwarded register operands (WIDTH bits)
//   flush             : synchronous clear of alu_out_q/zero_q
//   regdst .. jump    : main control outputs
//   aluop[1:0]        : ALUOp
//   aluctl[3:0]       : ALU operation code
//   wrreg[4:0]        : destination register (rd if regdst, else rt)
//   alu_out, zero     : combinational ALU result and zero flag
//   alu_out_q, zero_q : registered alu_out/zero
module mips_ex_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             flush,
  output logic             regdst,
  output logic             branch_eq,
  output logic             branch_ne,
  output logic             memread,
  output logic             memwrite,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             alusrc,
  output logic             jump,
  output logic [1:0]       aluop,
  output logic [3:0]       aluctl,
  output logic [4:0]       wrreg,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic [WIDTH-1:0] alu_out_q,
  output logic             zero_q
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  typedef enum logic [5:0] {
    FN_MUL = 6'h18,
    FN_ADD = 6'h20,
    FN_SUB = 6'h22,
    FN_AND = 6'h24,
    FN_OR  = 6'h25,
    FN_XOR = 6'h26,
    FN_NOR = 6'h27,
    FN_SLT = 6'h2A
  } funct_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_ADD2  = 2'b11
  } aluop_e;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_MUL = 4'b0011,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100,
    ALU_XOR = 4'b1101
  } aluctl_e;

  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [4:0]       rt_f;
  logic [4:0]       rd_f;
  logic [15:0]      imm;
  logic [WIDTH-1:0] imm_sext;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_res;

  assign opcode = instr[31:26];
  assign rt_f   = instr[20:16];
  assign rd_f   = instr[15:11];
  assign imm    = instr[15:0];
  assign funct  = instr[5:0];

  // Main control decode
  always_comb begin
    regdst    = 1'b0;
    branch_eq = 1'b0;
    branch_ne = 1'b0;
    memread   = 1'b0;
    memwrite  = 1'b0;
    memtoreg  = 1'b0;
    regwrite  = 1'b0;
    alusrc    = 1'b0;
    jump      = 1'b0;
    aluop     = ALUOP_ADD;
    case (opcode)
      OP_RTYPE: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        aluop    = ALUOP_FUNCT;
      end
      OP_LW: begin
        alusrc   = 1'b1;
        memread  = 1'b1;
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      OP_SW: begin
        alusrc   = 1'b1;
        memwrite = 1'b1;
      end
      OP_BEQ: begin
        branch_eq = 1'b1;
        aluop     = ALUOP_SUB;
      end
      OP_BNE: begin
        branch_ne = 1'b1;
        aluop     = ALUOP_SUB;
      end
      OP_ADDI: begin
        alusrc   = 1'b1;
        regwrite = 1'b1;
      end
      OP_J: begin
        jump = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU control
  always_comb begin
    aluctl = ALU_ADD;
    case (aluop)
      ALUOP_ADD, ALUOP_ADD2: aluctl = ALU_ADD;
      ALUOP_SUB:             aluctl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  aluctl = ALU_ADD;
          FN_SUB:  aluctl = ALU_SUB;
          FN_AND:  aluctl = ALU_AND;
          FN_OR:   aluctl = ALU_OR;
          FN_XOR:  aluctl = ALU_XOR;
          FN_NOR:  aluctl = ALU_NOR;
          FN_SLT:  aluctl = ALU_SLT;
          FN_MUL:  aluctl = ALU_MUL;
          default: aluctl = ALU_ADD;
        endcase
      end
      default: aluctl = ALU_ADD;
    endcase
  end

  assign wrreg    = regdst ? rd_f : rt_f;
  assign imm_sext = {{(WIDTH-16){imm[15]}}, imm};
  assign op_a     = rs_data;
  assign op_b     = alusrc ? imm_sext : rt_data;

  // ALU datapath
  always_comb begin
    alu_res = '0;
    case (aluctl)
      ALU_ADD: alu_res = op_a + op_b;
      ALU_SUB: alu_res = op_a - op_b;
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_XOR: alu_res = op_a ^ op_b;
      ALU_NOR: alu_res = ~(op_a | op_b);
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      // Low WIDTH bits of a product are identical for signed and unsigned
      // operands, so a WIDTH-wide multiply yields the signed product's low half.
      ALU_MUL: alu_res = op_a * op_b;
      default: alu_res = '0;
    endcase
  end

  assign alu_out = alu_res;
  assign zero    = (alu_res == '0);

  // EX/MEM boundary register: reset beats flush, flush beats load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_q <= '0;
      zero_q    <= 1'b0;
    end else if (flush) begin
      alu_out_q <= '0;
      zero_q    <= 1'b0;
    end else begin
      alu_out_q <= alu_out;
      zero_q    <= zero;
    end
  end

endmodule

// File: tb/tb_mips_ex_core.sv
module tb_mips_ex_core;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        regdst, branch_eq, branch_ne, memread, memwrite, memtoreg;
  logic        regwrite, alusrc, jump;
  logic [1:0]  aluop;
  logic [3:0]  aluctl;
  logic [4:0]  wrreg;
  logic [31:0] alu_out;
  logic        zero;
  logic [31:0] alu_out_q;
  logic        zero_q;

  int checks = 0;
  int errors = 0;

  mips_ex_core #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .instr     (instr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .flush     (flush),
    .regdst    (regdst),
    .branch_eq (branch_eq),
    .branch_ne (branch_ne),
    .memread   (memread),
    .memwrite  (memwrite),
    .memtoreg  (memtoreg),
    .regwrite  (regwrite),
    .alusrc    (alusrc),
    .jump      (jump),
    .aluop     (aluop),
    .aluctl    (aluctl),
    .wrreg     (wrreg),
    .alu_out   (alu_out),
    .zero      (zero),
    .alu_out_q (alu_out_q),
    .zero_q    (zero_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {regdst, branch_eq, branch_ne, memread, memwrite, memtoreg, regwrite, alusrc, jump}
  logic [8:0] ctl;
  assign ctl = {regdst, branch_eq, branch_ne, memread, memwrite, memtoreg,
                regwrite, alusrc, jump};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs mid-cycle and let combinational outputs settle
  task automatic apply(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    instr   = i;
    rs_data = a;
    rt_data = b;
    #1;
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    apply(32'h00221820, 32'd5, 32'd7);
    tick();
    chk("reset_q", {31'b0, alu_out_q, zero_q}, 64'd0);

    // R-type add $3,$1,$2
    chk("add_ctl",    ctl,     9'b100000100);
    chk("add_aluop",  aluop,   2'b10);
    chk("add_aluctl", aluctl,  4'b0010);
    chk("add_wrreg",  wrreg,   5'd3);
    chk("add_out",    alu_out, 32'd12);
    chk("add_zero",   zero,    1'b0);
    #2 rst_n = 1'b1;
    tick();
    chk("add_q",      alu_out_q, 32'd12);
    chk("add_zero_q", zero_q,    1'b0);

    // lw positive / negative offset
    apply(32'h8C410010, 32'h100, 32'hDEAD);
    chk("lw_ctl",    ctl,     9'b000101110);
    chk("lw_aluop",  aluop,   2'b00);
    chk("lw_wrreg",  wrreg,   5'd1);
    chk("lw_out",    alu_out, 32'h110);
    apply(32'h8C41FFFC, 32'h100, 32'hDEAD);
    chk("lw_neg",    alu_out, 32'hFC);

    // sw
    apply(32'hAC410010, 32'h100, 32'h5);
    chk("sw_ctl",    ctl,     9'b000010010);
    chk("sw_out",    alu_out, 32'h110);

    // beq equal / unequal, then register zero flag
    apply(32'h10220005, 32'd9, 32'd9);
    chk("beq_ctl",    ctl,     9'b010000000);
    chk("beq_aluop",  aluop,   2'b01);
    chk("beq_aluctl", aluctl,  4'b0110);
    chk("beq_zero",   zero,    1'b1);
    tick();
    chk("beq_zero_q", zero_q,    1'b1);
    chk("beq_q",      alu_out_q, 32'd0);
    apply(32'h10220005, 32'd9, 32'd8);
    chk("beq_ne_zero", zero,   1'b0);
    chk("beq_ne_out",  alu_out, 32'd1);

    // bne, addi, j
    apply(32'h14220005, 32'd3, 32'd3);
    chk("bne_ctl",   ctl,     9'b001000000);
    chk("bne_zero",  zero,    1'b1);
    apply(32'h20410005, 32'd10, 32'd99);
    chk("addi_ctl",  ctl,     9'b000000110);
    chk("addi_wr",   wrreg,   5'd1);
    chk("addi_out",  alu_out, 32'd15);
    apply(32'h08000010, 32'd1, 32'd2);
    chk("j_ctl",     ctl,     9'b000000001);
    chk("j_aluop",   aluop,   2'b00);

    // R-type function decode and signed ops
    apply(32'h0022182A, 32'hFFFFFFFF, 32'd1);
    chk("slt_aluctl", aluctl,  4'b0111);
    chk("slt_out",    alu_out, 32'd1);
    apply(32'h0022182A, 32'd1, 32'hFFFFFFFF);
    chk("slt_out0",   alu_out, 32'd0);
    apply(32'h00221818, 32'hFFFFFFFE, 32'd3);
    chk("mul_aluctl", aluctl,  4'b0011);
    chk("mul_out",    alu_out, 32'hFFFFFFFA);
    apply(32'h00221827, 32'd0, 32'd0);
    chk("nor_aluctl", aluctl,  4'b1100);
    chk("nor_out",    alu_out, 32'hFFFFFFFF);
    chk("nor_zero",   zero,    1'b0);
    apply(32'h00221822, 32'd5, 32'd7);
    chk("sub_aluctl", aluctl,  4'b0110);
    chk("sub_out",    alu_out, 32'hFFFFFFFE);
    apply(32'h00221824, 32'hF0F0, 32'hFF00);
    chk("and_aluctl", aluctl,  4'b0000);
    chk("and_out",    alu_out, 32'hF000);
    apply(32'h00221825, 32'hF0F0, 32'hFF00);
    chk("or_aluctl",  aluctl,  4'b0001);
    chk("or_out",     alu_out, 32'hFFF0);
    apply(32'h00221826, 32'hF0F0, 32'hFF00);
    chk("xor_aluctl", aluctl,  4'b1101);
    chk("xor_out",    alu_out, 32'h0FF0);
    apply(32'h0022183F, 32'd4, 32'd6);
    chk("fnx_aluctl", aluctl,  4'b0010);
    chk("fnx_out",    alu_out, 32'd10);

    // Unknown opcode
    apply(32'hFC000000, 32'd4, 32'd6);
    chk("unk_ctl",    ctl,     9'b000000000);
    chk("unk_aluop",  aluop,   2'b00);
    chk("unk_aluctl", aluctl,  4'b0010);
    chk("unk_wrreg",  wrreg,   5'd0);

    // Asynchronous reset pulse between edges
    apply(32'h00221820, 32'h30, 32'h3);
    tick();
    chk("pre_rst_q",  alu_out_q, 32'h33);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_q", {31'b0, alu_out_q, zero_q}, 64'd0);
    chk("rst_comb",    alu_out, 32'h33);
    tick();
    chk("rst_hold_q",  {31'b0, alu_out_q, zero_q}, 64'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("rst_rel_q",   alu_out_q, 32'h33);

    // Flush then resume
    apply(32'h00221820, 32'h50, 32'h5);
    chk("fl_out",     alu_out, 32'h55);
    flush = 1'b1;
    tick();
    chk("flush_q",    alu_out_q, 32'd0);
    chk("flush_zq",   zero_q,    1'b0);
    flush = 1'b0;
    tick();
    chk("unflush_q",  alu_out_q, 32'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mips_ex_core.md
# mips_ex_core

Combined decode/execute slice of the five-stage MIPS pipeline. It decodes the main control word from the instruction opcode, derives the 4-bit ALU operation from ALUOp and funct, and evaluates the ALU. It registers the result and zero flag into the EX/MEM boundary. All decode and ALU paths are combinational; only the result/zero pair is clocked.

## Interface
Parameters:
- `WIDTH`, 32: datapath width; `instr` is always 32 bits.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr`  in  32  instruction word: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm/funct [15:0]/[5:0].
- `rs_data`  in  WIDTH  operand A (already forwarded).
- `rt_data`  in  WIDTH  operand B register value (already forwarded).
- `flush`  in  1  synchronous clear of registered outputs.
- `regdst, branch_eq, branch_ne, memread, memwrite, memtoreg, regwrite, alusrc, jump`  out  1 each  main control.
- `aluop`  out  2  ALUOp.
- `aluctl`  out  4  ALU operation code.
- `wrreg`  out  5  destination: rd if regdst, else rt.
- `alu_out`  out  WIDTH  combinational ALU result.
- `zero`  out  1  alu_out == 0.
- `alu_out_q`  out  WIDTH  registered alu_out.
- `zero_q`  out  1  registered zero.

## Operation
Main control, opcode to asserted signals; all others 0, aluop 00:
- 0x00 R-type: regdst, regwrite, aluop=10.
- 0x23 lw: alusrc, memread, memtoreg, regwrite, aluop=00.
- 0x2B sw: alusrc, memwrite, aluop=00.
- 0x04 beq: branch_eq, aluop=01.
- 0x05 bne: branch_ne, aluop=01.
- 0x08 addi: alusrc, regwrite, aluop=00.
- 0x02 j: jump.
- Any other opcode: every control output 0.

ALU control:
- aluop 00 or 11: 0010 (add).
- aluop 01: 0110 (sub).
- aluop 10, funct to aluctl: 0x20 to 0010 add; 0x22 to 0110 sub; 0x24 to 0000 and; 0x25 to 0001 or; 0x26 to 1101 xor; 0x27 to 1100 nor; 0x2A to 0111 slt; 0x18 to 0011 mul.
- Any other funct: 0010.

ALU:
- Operand A is rs_data.
- Operand B is sign-extended imm[15:0] when alusrc = 1, else rt_data.
- add/sub: modulo 2^WIDTH, no overflow flag.
- slt: signed compare, result 1 or 0.
- mul: low WIDTH bits of the signed product.
- nor: ~(A|B).
- Undefined aluctl values produce 0.
- zero is computed from alu_out for every operation.

## Timing
- Control, aluctl, wrreg, alu_out and zero settle in the same cycle instr/operands are applied (0-cycle latency).
- alu_out_q/zero_q update on each rising clk edge from the current alu_out/zero (1-cycle latency).
- rst_n low asynchronously forces alu_out_q = 0 and zero_q = 0, and holds them there while low. Combinational outputs are unaffected by rst_n.
- flush = 1 at a rising edge loads alu_out_q = 0 and zero_q = 0. Reset has priority over flush; flush has priority over the normal load.
- Reset deasserted mid-stream: the first rising edge after release loads the current ALU values.
- There is no hold/enable input; the register loads every cycle.

## Test plan
- R-type add: instr 0x00221820 (add $3,$1,$2), rs_data=5, rt_data=7. Required: regdst=1, regwrite=1, aluop=10, aluctl=0010, wrreg=3, alu_out=12; alu_out_q=12 after one edge.
- lw: instr 0x8C410010, rs_data=0x100. Required: alusrc=memread=memtoreg=regwrite=1, wrreg=1, alu_out=0x110. A negative offset 0xFFFC yields 0xFC.
- beq equal/unequal: opcode 0x04, rs_data=rt_data=9. Required: aluctl=0110, zero=1, branch_eq=1. With rt_data=8: zero=0, alu_out=1.
- Signed ops: slt with A=0xFFFFFFFF, B=1 gives 1. mul with A=0xFFFFFFFE, B=3 gives 0xFFFFFFFA. nor with A=0, B=0 gives 0xFFFFFFFF.
- Unknown opcode 0x3F: all control outputs 0, aluctl=0010.
- Reset/flush: pulse rst_n low asynchronously between edges; alu_out_q and zero_q go to 0 immediately. Assert flush with alu_out=0x55; after the edge alu_out_q=0 and zero_q=0. On the next edge, with flush low, alu_out_q=0x55.
